// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control bundle widths, bit indices inside
// the bundles, ALU operation and opcode encodings, and the ID/EX record types.
package id_ex_stage_pkg;

    localparam int WB_W          = 5;   // {RegWrite,MemToReg,SLSE[2:0]}
    localparam int M_W           = 10;  // {Branch[2:0],JM[1:0],DV,MemRead,MemWrite,SaveSign[1:0]}
    localparam int EX_W          = 10;  // {ALUSrcA,ALUSrcB[1:0],ALUOP[4:0],RegDst[1:0]}
    localparam int REG_W         = 5;
    localparam int MEM_READ_BIT  = 3;   // inside the M bundle
    localparam int REG_WRITE_BIT = 4;   // inside the WB bundle
    localparam int CNT_W         = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_ADDU = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SUBU = 5'd3,
        ALU_AND  = 5'd4,
        ALU_OR   = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_NOR  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_SLL  = 5'd10,
        ALU_SRL  = 5'd11,
        ALU_SRA  = 5'd12,
        ALU_LUI  = 5'd13,
        ALU_MUL  = 5'd14,
        ALU_DIV  = 5'd15
    } alu_op_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    // What the ID/EX register does on the coming edge, highest priority last.
    typedef enum logic [2:0] {
        ACT_CAPTURE = 3'd0,
        ACT_BUBBLE  = 3'd1,
        ACT_HOLD    = 3'd2,
        ACT_FLUSH   = 3'd3,
        ACT_RESET   = 3'd4
    } stage_act_e;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
        logic            valid;
    } stage_ctrl_t;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] shamt;
    } stage_regs_t;

    function automatic logic is_mem_read(input logic [M_W-1:0] m);
        return m[MEM_READ_BIT];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a valid load sitting in EX whose destination
// (rt, never $zero) is a source of the valid instruction in decode.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic [M_W-1:0]   ex_m_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             hazard_o
);

    // Pure combinational compare against the load destination.
    always_comb begin
        hazard_o = ex_valid_i & is_mem_read(ex_m_i) & (ex_rt_i != '0) & id_valid_i &
                   ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and hold control.
// Optional build macro ID_EX_PERF_EN adds bubble/flush event counters.
// Handshake: pc_write_o/ifid_write_o low means fetch and decode must keep
// their current contents this cycle; priority is reset > flush > hold >
// load-use bubble > normal capture.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WB_W-1:0]  id_wb_i,
    input  logic [M_W-1:0]   id_m_i,
    input  logic [EX_W-1:0]  id_ex_i,
    input  logic             id_valid_i,
    input  logic [DW-1:0]    id_pc4_i,
    input  logic [DW-1:0]    id_rsd_i,
    input  logic [DW-1:0]    id_rtd_i,
    input  logic [DW-1:0]    id_imm_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic [REG_W-1:0] id_shamt_i,
    input  logic             flush_i,
    input  logic             hold_i,
`ifdef ID_EX_PERF_EN
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic [WB_W-1:0]  ex_wb_o,
    output logic [M_W-1:0]   ex_m_o,
    output logic [EX_W-1:0]  ex_ex_o,
    output logic             ex_valid_o,
    output logic [DW-1:0]    ex_pc4_o,
    output logic [DW-1:0]    ex_rsd_o,
    output logic [DW-1:0]    ex_rtd_o,
    output logic [DW-1:0]    ex_imm_o,
    output logic [REG_W-1:0] ex_rs_o,
    output logic [REG_W-1:0] ex_rt_o,
    output logic [REG_W-1:0] ex_rd_o,
    output logic [REG_W-1:0] ex_shamt_o,
    output logic             pc_write_o,
    output logic             ifid_write_o
);

    stage_ctrl_t ctrl_q, ctrl_d;
    stage_regs_t regs_q, regs_d;
    logic [DW-1:0] pc4_q, pc4_d, rsd_q, rsd_d, rtd_q, rtd_d, imm_q, imm_d;
    stage_act_e act;
    logic hazard;

    hazard_detect u_hazard_detect (
        .ex_valid_i (ctrl_q.valid),
        .ex_m_i     (ctrl_q.m),
        .ex_rt_i    (regs_q.rt),
        .id_valid_i (id_valid_i),
        .id_rs_i    (id_rs_i),
        .id_rt_i    (id_rt_i),
        .hazard_o   (hazard)
    );

    // Resolve the priority chain into a single action for this cycle.
    always_comb begin
        act = ACT_CAPTURE;
        if (!rst_n)       act = ACT_RESET;
        else if (flush_i) act = ACT_FLUSH;
        else if (hold_i)  act = ACT_HOLD;
        else if (hazard)  act = ACT_BUBBLE;
    end

    // Next register contents and fetch/decode write enables.
    always_comb begin
        ctrl_d = ctrl_q;
        regs_d = regs_q;
        pc4_d  = pc4_q;
        rsd_d  = rsd_q;
        rtd_d  = rtd_q;
        imm_d  = imm_q;
        case (act)
            ACT_CAPTURE, ACT_BUBBLE, ACT_FLUSH: begin
                // Data fields always follow decode; only a bubble's control is killed.
                regs_d = '{rs: id_rs_i, rt: id_rt_i, rd: id_rd_i, shamt: id_shamt_i};
                pc4_d  = id_pc4_i;
                rsd_d  = id_rsd_i;
                rtd_d  = id_rtd_i;
                imm_d  = id_imm_i;
                ctrl_d = '{wb: id_wb_i, m: id_m_i, ex: id_ex_i, valid: id_valid_i};
                if (act != ACT_CAPTURE) begin
                    ctrl_d = '0;
                end else if (!id_valid_i) begin
                    ctrl_d.wb = '0;
                    ctrl_d.m  = '0;
                end
            end
            ACT_RESET: begin
                ctrl_d = '0;
                regs_d = '0;
                pc4_d  = '0;
                rsd_d  = '0;
                rtd_d  = '0;
                imm_d  = '0;
            end
            default: ;
        endcase
        pc_write_o   = !((act == ACT_HOLD) || (act == ACT_BUBBLE));
        ifid_write_o = !((act == ACT_HOLD) || (act == ACT_BUBBLE));
    end

    // ID/EX register bank with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            regs_q <= '0;
            pc4_q  <= '0;
            rsd_q  <= '0;
            rtd_q  <= '0;
            imm_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            regs_q <= regs_d;
            pc4_q  <= pc4_d;
            rsd_q  <= rsd_d;
            rtd_q  <= rtd_d;
            imm_q  <= imm_d;
        end
    end

    assign ex_wb_o    = ctrl_q.wb;
    assign ex_m_o     = ctrl_q.m;
    assign ex_ex_o    = ctrl_q.ex;
    assign ex_valid_o = ctrl_q.valid;
    assign ex_rs_o    = regs_q.rs;
    assign ex_rt_o    = regs_q.rt;
    assign ex_rd_o    = regs_q.rd;
    assign ex_shamt_o = regs_q.shamt;
    assign ex_pc4_o   = pc4_q;
    assign ex_rsd_o   = rsd_q;
    assign ex_rtd_o   = rtd_q;
    assign ex_imm_o   = imm_q;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

    // Event counters; a hold cycle is neither a bubble nor a flush so both freeze.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(act == ACT_BUBBLE);
        flush_cnt_d  = flush_cnt_q + CNT_W'(act == ACT_FLUSH);
    end

    // Counter registers, cleared with the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of register operands, PC and immediate.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports id_wb_i  input  5  {RegWrite,MemToReg,SLSE[2:0]}; id_m_i  input  10  {Branch[2:0],JM[1:0],DV,MemRead,MemWrite,SaveSign[1:0]}; id_ex_i  input  10  {ALUSrcA,ALUSrcB[1:0],ALUOP[4:0],RegDst[1:0]}.
REQ-005 SHALL have ports id_valid_i  input  1  decode slot holds a real instruction; id_pc4_i, id_rsd_i, id_rtd_i, id_imm_i  input  DW each  PC+4, rs data, rt data, extended immediate.
REQ-006 SHALL have ports id_rs_i, id_rt_i, id_rd_i, id_shamt_i  input  5 each  register/shift fields.
REQ-007 SHALL have ports flush_i  input  1  branch/jump redirect kill; hold_i  input  1  downstream freeze.
REQ-008 SHALL have registered outputs ex_wb_o(5), ex_m_o(10), ex_ex_o(10), ex_valid_o(1), ex_pc4_o/ex_rsd_o/ex_rtd_o/ex_imm_o(DW), ex_rs_o/ex_rt_o/ex_rd_o/ex_shamt_o(5).
REQ-009 SHALL have combinational outputs pc_write_o  output  1 and ifid_write_o  output  1, both low to stall fetch/decode.

Function
REQ-010 SHALL capture all id_* inputs into ex_* outputs with one-cycle latency when no stall, flush or hold applies.
REQ-011 SHALL detect load-use hazard = ex_valid_o & ex_m_o[3] & (ex_rt_o!=0) & id_valid_i & (ex_rt_o==id_rs_i | ex_rt_o==id_rt_i).
REQ-012 SHALL, on hazard, drive pc_write_o=0 and ifid_write_o=0 in the same cycle and load a bubble (ex_wb_o=0, ex_m_o=0, ex_ex_o=0, ex_valid_o=0) at the next edge; data fields are don't-care.
REQ-013 SHALL insert exactly one bubble per load-use; the following cycle the held decode instruction is captured normally.
REQ-014 SHALL, on flush_i, load a bubble at the next edge and drive pc_write_o=1, ifid_write_o=1 regardless of hazard.
REQ-015 SHALL, on hold_i without flush_i, keep every ex_* register unchanged and drive pc_write_o=0, ifid_write_o=0.
REQ-016 SHALL apply priority rst_n low > flush_i > hold_i > hazard bubble > normal capture.
REQ-017 SHALL treat id_valid_i=0 as a bubble: ex_wb_o, ex_m_o zeroed, ex_valid_o=0, no hazard raised.
REQ-018 SHALL never raise a hazard against register 0.

Reset
REQ-019 SHALL, while rst_n low at a clock edge, clear every ex_* output to 0 (ex_valid_o=0).
REQ-020 SHALL drive pc_write_o=1 and ifid_write_o=1 while in reset; a hazard in flight at reset is discarded.

Configuration
REQ-021 SHALL, with ID_EX_PERF_EN defined, provide 32-bit output counters bubble_cnt_o (load-use bubbles) and flush_cnt_o (flush cycles), reset to 0, incrementing by 1 per event, wrapping from 0xFFFFFFFF to 0, frozen under hold_i.
REQ-022 SHALL, without ID_EX_PERF_EN, omit both counter ports and all counter logic.

Structure
REQ-023 SHALL take bundle widths (5/10/10) and bit indices (MemRead=3, RegWrite=4) from the shared pipeline package, alongside the ALUOP and opcode definitions.
REQ-024 SHALL contain one sub-module, hazard_detect, computing REQ-011 combinationally; the register bank stays in id_ex_stage.

Verification
REQ-025 SHALL test: LW $t0 in EX (ex_m_o[3]=1, ex_rt_o=8), decode ADD rs=8 -> pc_write_o=ifid_write_o=0 one cycle, ex_valid_o=0 next cycle, ADD captured cycle after.
REQ-026 SHALL test: LW with ex_rt_o=0, decode rs=0 -> no stall, capture proceeds.
REQ-027 SHALL test: hazard and flush_i same cycle -> bubble loaded, pc_write_o=1, bubble_cnt_o unchanged, flush_cnt_o +1.
REQ-028 SHALL test: hold_i for 3 cycles with ex_wb_o=5'b10010 -> outputs unchanged 3 cycles, then new decode captured on release.
REQ-029 SHALL test: rst_n low mid-stall -> all ex_* 0, pc_write_o=1 next cycle.
REQ-030 SHALL test (ID_EX_PERF_EN): bubble_cnt_o preset 0xFFFFFFFF, one hazard -> 0x00000000.
